// File: rtl/lsu_op_pkg.sv
// Shared types and helpers for the LSU output-peripheral bank.
// Size codes follow RISC-V funct3 load/store encoding.
package lsu_op_pkg;

   typedef enum logic [2:0] {
      FN_B  = 3'd0,
      FN_H  = 3'd1,
      FN_W  = 3'd2,
      FN_BU = 3'd4,
      FN_HU = 3'd5
   } funct_e;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } state_e;

   localparam int CH_HEX0 = 0;
   localparam int CH_HEX1 = 1;
   localparam int CH_HEX2 = 2;
   localparam int CH_HEX3 = 3;
   localparam int CH_HEX4 = 4;
   localparam int CH_HEX5 = 5;
   localparam int CH_HEX6 = 6;
   localparam int CH_HEX7 = 7;
   localparam int CH_LEDR = 8;
   localparam int CH_LEDG = 9;
   localparam int CH_LCD  = 10;

   function automatic logic [3:0] strb_of(
      input logic [2:0] funct,
      input logic [1:0] offset
   );
      logic [3:0] s;
      s = 4'b0000;
      case (funct)
         FN_B, FN_BU: s = 4'b0001 << offset;
         FN_H, FN_HU: s = 4'b0011 << offset;
         FN_W:        s = 4'b1111;
         default:     s = 4'b0000;
      endcase
      return s;
   endfunction

   // 1 when the size code is legal and the offset is naturally aligned.
   function automatic logic align_chk(
      input logic [2:0] funct,
      input logic [1:0] offset
   );
      logic ok;
      ok = 1'b0;
      case (funct)
         FN_B, FN_BU: ok = 1'b1;
         FN_H, FN_HU: ok = ~offset[0];
         FN_W:        ok = (offset == 2'b00);
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/op_blink_prescaler.sv
// Free-running blink prescaler: phase toggles every BLINK_DIV cycles.
module op_blink_prescaler #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic phase_o
);

   localparam int CW = $clog2(BLINK_DIV);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         phase_o <= 1'b0;
      end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
         cnt_q   <= '0;
         phase_o <= ~phase_o;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/lsu_op_bank_apb.sv
// APB output-peripheral bank: channel registers, blink mask, one-wait-state
// handshake with byte-lane addressing and registered read data.
module lsu_op_bank_apb #(
   parameter int          NUM_CH     = 11,
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_W     = 8,
   parameter logic [31:0] RST_VAL    = 32'h0,
   parameter int          BLINK_DIV  = 25_000_000
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         psel_i,
   input  logic                         penable_i,
   input  logic                         pwrite_i,
   input  logic [ADDR_W-1:0]            paddr_i,
   input  logic [31:0]                  pwdata_i,
   input  logic [2:0]                   pfunct_code_i,
   output logic [31:0]                  prdata_o,
   output logic                         pready_o,
   output logic                         pslverr_o,
   output logic [NUM_CH*DATA_WIDTH-1:0] io_ch_o
);
   import lsu_op_pkg::*;

   localparam int              KW     = ADDR_W - 2;
   localparam logic [KW-1:0]   K_MASK = KW'(NUM_CH);

   logic [DATA_WIDTH-1:0] ch_q [NUM_CH];
   logic [NUM_CH-1:0]     mask_q;
   state_e                state_q, state_d;
   logic                  phase;

   logic [KW-1:0] k;
   logic [1:0]    o;
   logic          acc, is_mask, err;
   logic [3:0]    strb;
   logic [31:0]   cur, shd, rd_val, lane_m, wr_val;

   assign k       = paddr_i[ADDR_W-1:2];
   assign o       = paddr_i[1:0];
   assign acc     = psel_i & penable_i & (state_q == ST_IDLE);
   assign is_mask = (k == K_MASK);
   assign err     = ~align_chk(pfunct_code_i, o) | (k > K_MASK);
   assign strb    = strb_of(pfunct_code_i, o);

   always_comb begin
      cur = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (k == KW'(c)) cur = ch_q[c];
      if (is_mask) cur = {{(DATA_WIDTH-NUM_CH){1'b0}}, mask_q};
   end

   assign shd = cur >> {o, 3'b000};

   always_comb begin
      rd_val = '0;
      case (pfunct_code_i)
         FN_B:    rd_val = {{24{shd[7]}}, shd[7:0]};
         FN_H:    rd_val = {{16{shd[15]}}, shd[15:0]};
         FN_W:    rd_val = shd;
         FN_BU:   rd_val = {24'b0, shd[7:0]};
         FN_HU:   rd_val = {16'b0, shd[15:0]};
         default: rd_val = '0;
      endcase
      if (err | pwrite_i) rd_val = '0;
   end

   assign lane_m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   assign wr_val = (cur & ~lane_m) | ((pwdata_i << {o, 3'b000}) & lane_m);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NUM_CH; c++) ch_q[c] <= RST_VAL;
         mask_q <= '0;
      end else if (acc & pwrite_i & ~err) begin
         for (int c = 0; c < NUM_CH; c++)
            if (k == KW'(c)) ch_q[c] <= wr_val;
         if (is_mask) mask_q <= wr_val[NUM_CH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         prdata_o  <= '0;
         pslverr_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         prdata_o  <= acc ? rd_val : '0;
         pslverr_o <= acc & err;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (psel_i & penable_i) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign pready_o = (state_q == ST_RESP);

   op_blink_prescaler #(
      .BLINK_DIV(BLINK_DIV)
   ) u_presc (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .phase_o(phase)
   );

   // Blanking only affects the board outputs; reads see the raw register.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_out
      assign io_ch_o[c*DATA_WIDTH +: DATA_WIDTH] =
         (mask_q[c] & phase) ? '0 : ch_q[c];
   end

endmodule

// File: tb/tb_lsu_op_bank_apb.sv
// Randomized bench for lsu_op_bank_apb against a byte-level reference model.
module tb_lsu_op_bank_apb;

   localparam int NCH = 11;
   localparam int DIV = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           psel = 1'b0;
   logic           penable = 1'b0;
   logic           pwrite = 1'b0;
   logic [7:0]     paddr = '0;
   logic [31:0]    pwdata = '0;
   logic [2:0]     pfunct = '0;
   logic [31:0]    prdata;
   logic           pready;
   logic           pslverr;
   logic [NCH*32-1:0] io;

   int n_cmp = 0;
   int n_bad = 0;
   int ecnt = 0;

   logic [31:0]    m_ch [NCH];
   logic [NCH-1:0] m_mask;

   lsu_op_bank_apb #(
      .BLINK_DIV(DIV)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .psel_i       (psel),
      .penable_i    (penable),
      .pwrite_i     (pwrite),
      .paddr_i      (paddr),
      .pwdata_i     (pwdata),
      .pfunct_code_i(pfunct),
      .prdata_o     (prdata),
      .pready_o     (pready),
      .pslverr_o    (pslverr),
      .io_ch_o      (io)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) ecnt <= 0;
      else ecnt <= ecnt + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_phase();
      return ((ecnt / DIV) % 2) == 1;
   endfunction

   task automatic m_clear();
      for (int c = 0; c < NCH; c++) m_ch[c] = '0;
      m_mask = '0;
   endtask

   task automatic check_io();
      for (int c = 0; c < NCH; c++)
         chk($sformatf("io%0d", c), io[c*32 +: 32],
             (m_mask[c] && m_phase()) ? 32'h0 : m_ch[c]);
   endtask

   task automatic model(input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        output logic [31:0] er, output bit ee);
      int k, o, sz;
      bit ok;
      logic [31:0] cur, v;
      k  = int'(a[7:2]);
      o  = int'(a[1:0]);
      sz = (f == 0 || f == 4) ? 1 : (f == 1 || f == 5) ? 2 : (f == 2) ? 4 : 0;
      ok = (sz != 0) && (k <= NCH);
      if (ok) ok = (o % sz) == 0;
      cur = (k < NCH) ? m_ch[k] : (k == NCH) ? 32'(m_mask) : 32'h0;
      er = '0;
      ee = !ok;
      if (ok && wr) begin
         for (int i = 0; i < sz; i++) cur[8*(o+i) +: 8] = d[8*i +: 8];
         if (k < NCH) m_ch[k] = cur;
         else m_mask = cur[NCH-1:0];
      end else if (ok) begin
         v = cur >> (8 * o);
         if (sz == 1) v = (f == 0) ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
         if (sz == 2) v = (f == 1) ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
         er = v;
      end
   endtask

   task automatic apb(input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [2:0] f,
                      output logic [31:0] rd);
      logic [31:0] er;
      bit ee;
      model(wr, a, d, f, er, ee);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = d; pfunct = f;
      @(negedge clk);
      penable = 1'b1;
      #1 chk("rdy_setup", 32'(pready), 32'h0);
      @(negedge clk);
      chk("rdy_resp", 32'(pready), 32'h1);
      chk("slverr", 32'(pslverr), 32'(ee));
      if (!wr) chk("rdata", prdata, er);
      rd = prdata;
      check_io();
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("rdy_idle", 32'(pready), 32'h0);
      chk("rdata_idle", prdata, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      int kk, ff;
      logic [7:0] aa;

      m_clear();
      repeat (2) @(negedge clk);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_pready", 32'(pready), 32'h0);
      chk("rst_slverr", 32'(pslverr), 32'h0);
      check_io();
      rst_n = 1'b1;

      apb(1, 8'h04, 32'h12345678, 3'd2, rd);
      apb(0, 8'h04, 32'h0, 3'd2, rd);
      chk("t1_word", rd, 32'h12345678);
      chk("t1_io", io[32 +: 32], 32'h12345678);

      apb(1, 8'h04, 32'h0, 3'd2, rd);
      apb(1, 8'h06, 32'h000000AB, 3'd0, rd);
      chk("t2_io", io[32 +: 32], 32'h00AB0000);
      apb(0, 8'h06, 32'h0, 3'd0, rd);
      chk("t2_lb", rd, 32'hFFFFFFAB);
      apb(0, 8'h06, 32'h0, 3'd4, rd);
      chk("t2_lbu", rd, 32'h000000AB);

      apb(1, 8'h00, 32'h00000055, 3'd2, rd);
      apb(1, 8'h01, 32'h0000BEEF, 3'd1, rd);
      chk("t3_ch0", io[31:0], 32'h00000055);
      apb(0, 8'h30, 32'h0, 3'd2, rd);
      chk("t3_oor", rd, 32'h0);

      apb(1, 8'h20, 32'h000000FF, 3'd2, rd);
      apb(1, 8'h2C, 32'h00000100, 3'd2, rd);
      for (int i = 0; i < 3 * DIV; i++) begin
         @(negedge clk);
         chk("t4_blink", io[8*32 +: 32], m_phase() ? 32'h0 : 32'hFF);
      end
      for (int i = 0; i < 2 * DIV && !m_phase(); i++) @(negedge clk);
      apb(0, 8'h20, 32'h0, 3'd2, rd);
      chk("t4_raw", rd, 32'hFF);
      apb(0, 8'h2C, 32'h0, 3'd2, rd);
      chk("t4_mask", rd, 32'h100);
      apb(1, 8'h2C, 32'h0, 3'd2, rd);
      chk("t4_unblank", io[8*32 +: 32], 32'hFF);

      // reset during the access cycle of a write
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 8'h00; pwdata = 32'hDEADBEEF; pfunct = 3'd2;
      @(negedge clk);
      penable = 1'b1;
      #2 rst_n = 1'b0;
      m_clear();
      #1 chk("t5_rdy", 32'(pready), 32'h0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      chk("t5_ch0", io[31:0], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check_io();
      apb(0, 8'h00, 32'h0, 3'd2, rd);
      chk("t5_rd", rd, 32'h0);

      // reset during the response cycle
      apb(1, 8'h08, 32'h11223344, 3'd2, rd);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h08; pfunct = 3'd2;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      chk("t5b_rdy1", 32'(pready), 32'h1);
      rst_n = 1'b0;
      m_clear();
      #1 chk("t5b_rdy0", 32'(pready), 32'h0);
      chk("t5b_rdata", prdata, 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_io();

      apb(1, 8'h0C, 32'hCAFEF00D, 3'd2, rd);
      apb(1, 8'h0C, 32'h12345678, 3'd3, rd);
      apb(0, 8'h0C, 32'h0, 3'd3, rd);
      apb(1, 8'h0C, 32'h0, 3'd6, rd);
      apb(0, 8'h0C, 32'h0, 3'd7, rd);
      chk("t6_ch3", io[3*32 +: 32], 32'hCAFEF00D);

      for (int n = 0; n < 400; n++) begin
         kk = $urandom_range(0, 13);
         ff = $urandom_range(0, 7);
         aa = {kk[5:0], 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 3) == 0) ff = 2;
         apb(1'($urandom_range(0, 1)), aa, $urandom, 3'(ff), rd);
         if ($urandom_range(0, 4) == 0)
            repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      check_io();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
